uart_apu_loader: RTL
====================

// Module: uart_apu_loader
// PURPOSE
//  Serial front end of the sound core. Receives 8N1 UART bytes from the host, decodes nibble commands and
//  loads the four 8-bit square-channel registers (duty/envelope, sweep, timer-lo, length/timer-hi).
//  Feeds the square-wave generator; a reg3 load is the channel (re)start trigger.
//  Command byte: bit7=0, [6:4]=index, [3:0]=nibble. Even index = low nibble, odd = high nibble of reg[index>>1].
// PARAMETERS
//  CLK_HZ    12_000_000  system clock frequency, Hz
//  BAUD      9_600       UART bit rate; BIT_DIV = CLK_HZ/BAUD (1250 at defaults), HALF_DIV = BIT_DIV/2
// PORTS
//  clk        in   1   system clock; all logic on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  rx         in   1   UART serial input, idle high, async to clk
//  reg0       out  8   duty/envelope register
//  reg1       out  8   sweep register
//  reg2       out  8   timer low register
//  reg3       out  8   length/timer high register
//  reg_wr     out  4   one-cycle load strobe, bit n = reg<n> updated this cycle
//  trigger    out  1   one-cycle pulse, equals reg_wr[3]
//  frame_err  out  1   one-cycle pulse, stop bit sampled low
// BEHAVIOUR
//  Reset: reg0..reg3=8'h00, reg_wr=0, trigger=0, frame_err=0, rx synchroniser=1, FSM=IDLE, pend_vld=0.
//  Reset mid-frame aborts the byte; no partial load.
//  rx goes through a 2-FF synchroniser (reset to 1); all decisions use the synchronised value rxs.
//  RX FSM, counter cnt counts clk cycles:
//   IDLE  : rxs==0 -> START, cnt=0.
//   START : at cnt==HALF_DIV-1 sample; rxs==1 -> IDLE (glitch, no byte); else -> DATA, cnt=0, bit=0.
//   DATA  : at cnt==BIT_DIV-1 sample rxs into shift[bit], LSB first; after bit 7 -> STOP.
//   STOP  : at cnt==BIT_DIV-1 sample; rxs==1 -> byte_vld 1 cycle, -> IDLE.
//           rxs==0 -> frame_err 1 cycle, byte dropped, -> BREAK.
//   BREAK : wait for rxs==1, then -> IDLE. Prevents a false start inside a low line.
//  Decoder, acts in the cycle after byte_vld:
//   bit7==1 -> byte ignored, no state change.
//   even index i: pend_nib=nibble, pend_idx=i, pend_vld=1. A later even index overwrites it.
//   odd index i with pend_vld && pend_idx==i-1: reg[i>>1] <= {nibble,pend_nib}, reg_wr[i>>1]=1, pend_vld=0.
//   odd index otherwise: dropped, pend_vld=0.
//  Latency: register value and reg_wr change on the same edge, 1 clk after the stop-bit sample.
//   That edge is about 9.5 bit times after the start-bit falling edge.
//  Registers hold their value until reloaded. Writing an equal value still pulses reg_wr.
//  Only one byte is in flight, so no simultaneous loads. reg_wr is one-hot or zero.
// TESTING
//  1 Send 27 3A 02 18 4C 57 69 70 at 9600 baud -> reg1=A7, reg0=82, reg2=7C, reg3=09.
//    reg_wr pulses 2,1,4,8 in that order; trigger pulses once with reg3.
//  2 Send 3A alone after reset -> no reg_wr, reg1 stays 00. Then 27 23 3A -> reg1=A3.
//    23 overwrites pending 7 with 3.
//  3 Send byte 27 with stop bit driven 0 -> frame_err 1-cycle pulse, no pend.
//    rx held low 3 bit times then 27 3A -> reg1=A7 only after the line returns high.
//  4 Low glitch of 400 clk on idle rx -> FSM back to IDLE, no byte_vld, no frame_err.
//  5 Send A7 (bit7 set) between 27 and 3A -> ignored, reg1=A7 still loads.
//  6 Assert rst_n low during DATA of 3A after 27 -> all outputs 0 immediately.
//    After release, 3A alone is dropped because pend was cleared.

Source files
------------

// File: rtl/uart_apu_loader.sv
// Receives 8N1 UART bytes from the host and loads the four square-channel registers from nibble command pairs.
// Latency: register and reg_wr update one clk after the stop-bit sample (about 9.5 bit times after the start edge).
// No backpressure: one byte in flight at a time; a frame with a low stop bit is dropped and the line must go high again.
module uart_apu_loader #(
    parameter int CLK_HZ = 12_000_000,
    parameter int BAUD   = 9_600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] reg0,
    output logic [7:0] reg1,
    output logic [7:0] reg2,
    output logic [7:0] reg3,
    output logic [3:0] reg_wr,
    output logic       trigger,
    output logic       frame_err
);

    localparam int BIT_DIV  = CLK_HZ / BAUD;
    localparam int HALF_DIV = BIT_DIV / 2;
    localparam int CW       = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    logic            sync1_q;
    logic            rxs_q;
    rx_state_t       state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            byte_vld_q;
    logic            frame_err_q;

    logic [3:0][7:0] regs_q,     regs_d;
    logic [3:0]      reg_wr_q,   reg_wr_d;
    logic [3:0]      pend_nib_q, pend_nib_d;
    logic [2:0]      pend_idx_q, pend_idx_d;
    logic            pend_vld_q, pend_vld_d;

    logic [2:0]      cmd_idx;
    logic [3:0]      cmd_nib;

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rx;
            rxs_q   <= sync1_q;
        end
    end

    // Receive FSM: mid-bit sampling, LSB first, with break handling after a bad stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!rxs_q) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        // A start bit that has gone high again by mid-bit is a glitch.
                        state_q <= rxs_q ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rxs_q, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (rxs_q) begin
                            byte_vld_q <= 1'b1;
                            state_q    <= ST_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_BREAK: begin
                    // Hold off until the line is released so a long low is not read as a start bit.
                    if (rxs_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_idx = shift_q[6:4];
    assign cmd_nib = shift_q[3:0];

    // Command decode: even index parks the low nibble, the matching odd index completes the load.
    always_comb begin
        regs_d     = regs_q;
        reg_wr_d   = '0;
        pend_nib_d = pend_nib_q;
        pend_idx_d = pend_idx_q;
        pend_vld_d = pend_vld_q;
        if (byte_vld_q && !shift_q[7]) begin
            if (!cmd_idx[0]) begin
                pend_nib_d = cmd_nib;
                pend_idx_d = cmd_idx;
                pend_vld_d = 1'b1;
            end else begin
                pend_vld_d = 1'b0;
                if (pend_vld_q && (pend_idx_q == (cmd_idx - 3'd1))) begin
                    regs_d[cmd_idx[2:1]]   = {cmd_nib, pend_nib_q};
                    reg_wr_d[cmd_idx[2:1]] = 1'b1;
                end
            end
        end
    end

    // Channel registers, load strobes and the pending low nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q     <= '0;
            reg_wr_q   <= '0;
            pend_nib_q <= '0;
            pend_idx_q <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            reg_wr_q   <= reg_wr_d;
            pend_nib_q <= pend_nib_d;
            pend_idx_q <= pend_idx_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    assign reg0      = regs_q[0];
    assign reg1      = regs_q[1];
    assign reg2      = regs_q[2];
    assign reg3      = regs_q[3];
    assign reg_wr    = reg_wr_q;
    assign trigger   = reg_wr_q[3];
    assign frame_err = frame_err_q;

endmodule
